hv_reg_access_arb_n: RTL and testbench
======================================

// Module: hv_reg_access_arb_n
// PURPOSE
//  N-channel register-access arbiter between bus masters (SPI slave, OWT RX, WDG scan, ...) and the reg bank.
//  Selectable fixed-priority or round-robin arbitration; one transaction in flight, tracked by an FSM.
//  Routes wack/rack/rdata/rcrc to the granted channel only; an ack watchdog converts a lost ack into a per-channel error.
// PARAMETERS
//  N_CH       3   number of requesting channels (>=2); channel 0 = highest priority in fixed mode
//  REG_AW     7   register address width
//  REG_DW     8   register data width
//  REG_CRC_W  8   register CRC width
//  ARB_MODE   0   0 = fixed priority (lowest index wins), 1 = round-robin
//  ACK_TO     15  WAIT cycles without a matching ack before error abort (>=2)
// PORTS
//  i_clk          in   1               clock
//  i_rst          in   1               synchronous, active-high reset
//  i_ch_wr_req    in   N_CH            per-channel write request, level, held until ack/err
//  i_ch_rd_req    in   N_CH            per-channel read request, level, held until ack/err
//  i_ch_addr      in   N_CH*REG_AW     per-channel address, channel k at [k*REG_AW +: REG_AW]
//  i_ch_wdata     in   N_CH*REG_DW     per-channel write data
//  i_ch_wcrc      in   N_CH*REG_CRC_W  per-channel write CRC
//  o_ch_wack      out  N_CH            one-cycle write done, granted channel only
//  o_ch_rack      out  N_CH            one-cycle read done, granted channel only
//  o_ch_err       out  N_CH            one-cycle ack-timeout abort, granted channel only
//  o_rsp_rdata    out  REG_DW          shared read data; valid only with an o_ch_rack bit
//  o_rsp_rcrc     out  REG_CRC_W       shared read CRC; valid only with an o_ch_rack bit
//  o_reg_wen      out  1               one-cycle write strobe to reg bank
//  o_reg_ren      out  1               one-cycle read strobe to reg bank
//  o_reg_addr     out  REG_AW          registered address, held until next issue
//  o_reg_wdata    out  REG_DW          registered write data, updated on write issue only
//  o_reg_wcrc     out  REG_CRC_W       registered write CRC, updated on write issue only
//  i_reg_wack     in   1               reg bank write ack
//  i_reg_rack     in   1               reg bank read ack
//  i_reg_rdata    in   REG_DW          reg bank read data
//  i_reg_rcrc     in   REG_CRC_W       reg bank read CRC
//  o_busy         out  1               FSM not IDLE
//  o_grant_id     out  $clog2(N_CH)    index of current/last granted channel
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0; RR pointer=0; timeout counter=0. Reset mid-transaction abandons it; no ack/err issued.
//  - Channel k requests when wr_req[k]|rd_req[k]; wr and rd both high => write.
//  - FSM IDLE: any request => pick winner, latch id/op/addr/wdata/wcrc, go ISSUE. ISSUE (1 cycle): o_reg_wen or o_reg_ren=1 -> WAIT.
//  - WAIT: counter +1 per cycle. Matching ack (i_reg_wack for write, i_reg_rack for read) => combinational
//    o_ch_wack/rack[id]=1 that cycle, o_rsp_* = i_reg_*, -> IDLE. Non-matching ack ignored.
//  - Counter reaching ACK_TO with no matching ack => o_ch_err[id]=1 for 1 cycle -> IDLE. An ack in the same cycle wins over timeout.
//  - Acks outside WAIT are ignored; never routed.
//  - Latency: request seen in IDLE at cycle t => strobe at t+1, earliest response t+2. Min 3 cycles per transaction.
//    Requester drops its request in its ack/err cycle; re-arbitration happens next IDLE cycle.
//  - Fixed mode: lowest set index wins. RR mode: search from pointer upward with wrap; on completion (ack or err)
//    pointer = id+1, wrapping N_CH-1 -> 0. Pointer frozen while IDLE with no requests.
//  - Requests changing during ISSUE/WAIT have no effect; latched fields are used.
//  - o_grant_id updates on grant and holds after completion.
// STRUCTURE
//  - hv_rac_pkg: typedef enum {IDLE, ISSUE, WAIT} rac_st_e; ARB_FIXED=0, ARB_RR=1; WR_OP/RD_OP.
//  - Sub-module hv_rr_arb #(N_CH): request vector + pointer + mode -> one-hot grant + index; combinational.
//  - Timeout counter width $clog2(ACK_TO+1).
// TESTING
//  1 Single write: ch1 wr addr=0x12 data=0xA5, bank wacks 1 cycle after wen -> o_reg_wen at t+1, o_ch_wack=3'b010 at t+2, wdata=0xA5.
//  2 Read: ch0 rd addr=0x05, rack 2 cycles after ren with rdata=0x3C -> o_ch_rack=3'b001, o_rsp_rdata=0x3C; ch1/ch2 acks stay 0.
//  3 Fixed contention: ch0,ch2 request together, ARB_MODE=0 -> ch0 served first, then ch2; o_grant_id 0 then 2.
//  4 RR fairness: ARB_MODE=1, all 3 hold requests, 6 transactions -> grant order 0,1,2,0,1,2.
//  5 Timeout: ch2 rd, no rack, ACK_TO=15 -> o_ch_err=3'b100 exactly 15 cycles after entering WAIT; late rack not routed.
//  6 Reset in WAIT: assert i_rst for 1 cycle -> all outputs 0, o_busy=0, no ack/err; next request served normally.

Source files
------------

// File: rtl/hv_rac_pkg.sv
// Shared types and constants for the register-access arbiter.
// FSM states, arbitration modes and operation encodings.
package hv_rac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } rac_st_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic WR_OP = 1'b1;
  localparam logic RD_OP = 1'b0;

endpackage

// File: rtl/hv_rr_arb.sv
// Combinational N-way arbiter: fixed priority or round-robin
// search starting at ptr; returns one-hot grant and its index.
module hv_rr_arb
  import hv_rac_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            mode,
  output logic [N_CH-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int base;
  int j;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    j    = 0;
    base = (int'(mode) == ARB_RR) ? int'(ptr) : 0;
    for (int i = 0; i < N_CH; i++) begin
      j = (base + i) % N_CH;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/hv_reg_access_arb_n.sv
// N-channel register-access arbiter: one transaction in flight,
// ack routed to the granted channel, lost acks become errors.
module hv_reg_access_arb_n
  import hv_rac_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int ARB_MODE  = 0,
  parameter int ACK_TO    = 15
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_CH-1:0]             i_ch_wr_req,
  input  logic [N_CH-1:0]             i_ch_rd_req,
  input  logic [N_CH*REG_AW-1:0]      i_ch_addr,
  input  logic [N_CH*REG_DW-1:0]      i_ch_wdata,
  input  logic [N_CH*REG_CRC_W-1:0]   i_ch_wcrc,
  output logic [N_CH-1:0]             o_ch_wack,
  output logic [N_CH-1:0]             o_ch_rack,
  output logic [N_CH-1:0]             o_ch_err,
  output logic [REG_DW-1:0]           o_rsp_rdata,
  output logic [REG_CRC_W-1:0]        o_rsp_rcrc,
  output logic                        o_reg_wen,
  output logic                        o_reg_ren,
  output logic [REG_AW-1:0]           o_reg_addr,
  output logic [REG_DW-1:0]           o_reg_wdata,
  output logic [REG_CRC_W-1:0]        o_reg_wcrc,
  input  logic                        i_reg_wack,
  input  logic                        i_reg_rack,
  input  logic [REG_DW-1:0]           i_reg_rdata,
  input  logic [REG_CRC_W-1:0]        i_reg_rcrc,
  output logic                        o_busy,
  output logic [$clog2(N_CH)-1:0]     o_grant_id
);

  localparam int IW = $clog2(N_CH);
  localparam int CW = $clog2(ACK_TO + 1);

  rac_st_e st, st_nxt;

  logic            op;
  logic [IW-1:0]   id;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] gnt;
  logic [N_CH-1:0] sel;
  logic [IW-1:0]   widx;
  logic            any;
  logic            wr_sel;
  logic            hit;
  logic            tmo;
  logic            live;

  assign req    = i_ch_wr_req | i_ch_rd_req;
  assign wr_sel = |(gnt & i_ch_wr_req);

  hv_rr_arb #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .mode (ARB_MODE == ARB_RR),
    .gnt  (gnt),
    .idx  (widx),
    .any  (any)
  );

  assign hit = (st == WAIT) &&
               ((op == WR_OP) ? i_reg_wack : i_reg_rack);
  // An ack arriving on the last allowed cycle beats the timeout.
  assign tmo = (st == WAIT) && !hit && (cnt == CW'(ACK_TO));

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (any) st_nxt = ISSUE;
      ISSUE:   st_nxt = WAIT;
      WAIT:    if (hit || tmo) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st          <= IDLE;
      op          <= RD_OP;
      id          <= '0;
      ptr         <= '0;
      cnt         <= '0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_reg_wcrc  <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= (st == WAIT) ? cnt + 1'b1 : '0;
      if (st == IDLE && any) begin
        id         <= widx;
        op         <= wr_sel;
        o_reg_addr <= i_ch_addr[widx*REG_AW +: REG_AW];
        if (wr_sel) begin
          o_reg_wdata <= i_ch_wdata[widx*REG_DW +: REG_DW];
          o_reg_wcrc  <= i_ch_wcrc[widx*REG_CRC_W +: REG_CRC_W];
        end
      end
      if (hit || tmo)
        ptr <= (id == IW'(N_CH - 1)) ? '0 : id + 1'b1;
    end
  end

  // Reset cycle masks everything so an abandoned transfer never acks.
  assign live = !i_rst;
  assign sel  = N_CH'(1) << id;

  assign o_busy     = live && (st != IDLE);
  assign o_grant_id = id;
  assign o_reg_wen  = live && (st == ISSUE) && (op == WR_OP);
  assign o_reg_ren  = live && (st == ISSUE) && (op == RD_OP);

  assign o_ch_wack = (live && hit && op == WR_OP) ? sel : '0;
  assign o_ch_rack = (live && hit && op == RD_OP) ? sel : '0;
  assign o_ch_err  = (live && tmo) ? sel : '0;

  assign o_rsp_rdata = (live && hit && op == RD_OP) ? i_reg_rdata : '0;
  assign o_rsp_rcrc  = (live && hit && op == RD_OP) ? i_reg_rcrc : '0;

endmodule

// File: tb/tb_hv_reg_access_arb_n.sv
// Directed bench for hv_reg_access_arb_n: fixed-priority and
// round-robin instances share a behavioural register bank.
module tb_hv_reg_access_arb_n;

  typedef struct {
    logic [2:0] wack;
    logic [2:0] rack;
    logic [2:0] err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sbq[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  f_wr = '0, f_rd = '0, r_wr = '0, r_rd = '0;
  logic [20:0] addr = '0;
  logic [23:0] wdata = '0, wcrc = '0;
  logic [7:0]  bk_rdata = '0, bk_rcrc = '0;
  logic        tb_wack = 1'b0, tb_rack = 1'b0;
  logic        bank_wack = 1'b0, bank_rack = 1'b0;
  logic        i_reg_wack, i_reg_rack;
  int          bk_dly = 0;
  logic        rr_sel = 1'b0;

  logic [2:0] f_wack, f_rack, f_err, r_wack, r_rack, r_err;
  logic [7:0] f_rdata, f_rcrc, r_rdata, r_rcrc;
  logic [7:0] f_wdata, f_wcrc, r_wdata, r_wcrc;
  logic [6:0] f_addr, r_addr;
  logic       f_wen, f_ren, r_wen, r_ren, f_busy, r_busy;
  logic [1:0] f_gid, r_gid;

  logic [2:0] m_wack, m_rack, m_err;
  logic [7:0] m_rdata;

  int total = 0;
  int passed = 0;

  assign i_reg_wack = bank_wack | tb_wack;
  assign i_reg_rack = bank_rack | tb_rack;
  assign m_wack  = rr_sel ? r_wack  : f_wack;
  assign m_rack  = rr_sel ? r_rack  : f_rack;
  assign m_err   = rr_sel ? r_err   : f_err;
  assign m_rdata = rr_sel ? r_rdata : f_rdata;

  always #5 clk = ~clk;

  hv_reg_access_arb_n #(.ARB_MODE(0), .ACK_TO(15)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ch_wr_req(f_wr), .i_ch_rd_req(f_rd),
    .i_ch_addr(addr), .i_ch_wdata(wdata), .i_ch_wcrc(wcrc),
    .o_ch_wack(f_wack), .o_ch_rack(f_rack), .o_ch_err(f_err),
    .o_rsp_rdata(f_rdata), .o_rsp_rcrc(f_rcrc),
    .o_reg_wen(f_wen), .o_reg_ren(f_ren), .o_reg_addr(f_addr),
    .o_reg_wdata(f_wdata), .o_reg_wcrc(f_wcrc),
    .i_reg_wack(i_reg_wack), .i_reg_rack(i_reg_rack),
    .i_reg_rdata(bk_rdata), .i_reg_rcrc(bk_rcrc),
    .o_busy(f_busy), .o_grant_id(f_gid)
  );

  hv_reg_access_arb_n #(.ARB_MODE(1), .ACK_TO(15)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_ch_wr_req(r_wr), .i_ch_rd_req(r_rd),
    .i_ch_addr(addr), .i_ch_wdata(wdata), .i_ch_wcrc(wcrc),
    .o_ch_wack(r_wack), .o_ch_rack(r_rack), .o_ch_err(r_err),
    .o_rsp_rdata(r_rdata), .o_rsp_rcrc(r_rcrc),
    .o_reg_wen(r_wen), .o_reg_ren(r_ren), .o_reg_addr(r_addr),
    .o_reg_wdata(r_wdata), .o_reg_wcrc(r_wcrc),
    .i_reg_wack(i_reg_wack), .i_reg_rack(i_reg_rack),
    .i_reg_rdata(bk_rdata), .i_reg_rcrc(bk_rcrc),
    .o_busy(r_busy), .o_grant_id(r_gid)
  );

  // Register bank: sees a strobe, acks bk_dly cycles later (0 = never).
  always begin : bank
    logic pend, bwr, stb;
    int   bcnt;
    pend = 1'b0;
    bwr  = 1'b0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      stb = f_wen | f_ren | r_wen | r_ren;
      if (stb && bk_dly > 0) begin
        pend = 1'b1;
        bwr  = f_wen | r_wen;
        bcnt = bk_dly;
      end
      @(posedge clk);
      #1;
      bank_wack = 1'b0;
      bank_rack = 1'b0;
      if (pend) begin
        bcnt--;
        if (bcnt == 0) begin
          pend = 1'b0;
          if (bwr) bank_wack = 1'b1;
          else     bank_rack = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic expect_rsp(input int budget, input string tag);
    exp_t e;
    int   n;
    logic got;
    n = 0;
    while (n < budget && (m_wack | m_rack | m_err) == 3'b0) begin
      @(negedge clk);
      n++;
    end
    got = (m_wack | m_rack | m_err) != 3'b0;
    chk({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_sbq"}, 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({tag, "_wack"}, 32'(m_wack), 32'(e.wack));
        chk({tag, "_rack"}, 32'(m_rack), 32'(e.rack));
        chk({tag, "_err"},  32'(m_err),  32'(e.err));
        if (e.rack != 3'b0)
          chk({tag, "_rdata"}, 32'(m_rdata), 32'(e.rdata));
      end
    end
  endtask

  task automatic push(input logic [2:0] w, input logic [2:0] r,
                      input logic [2:0] er, input logic [7:0] d);
    exp_t e;
    e.wack = w; e.rack = r; e.err = er; e.rdata = d;
    sbq.push_back(e);
  endtask

  initial begin
    logic quiet;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(f_busy), 0);
    chk("rst_out", 32'({f_wack, f_rack, f_err, f_wen, f_ren}), 0);
    chk("rst_addr", 32'({f_addr, f_wdata, f_gid}), 0);
    rst = 1'b0;
    @(negedge clk);

    // single write ch1
    addr[13:7] = 7'h12; wdata[15:8] = 8'hA5; wcrc[15:8] = 8'h5A;
    bk_dly = 1; f_wr = 3'b010;
    push(3'b010, 3'b000, 3'b000, 8'h00);
    @(negedge clk);
    chk("wr_wen", 32'({f_wen, f_ren}), 32'b10);
    chk("wr_addr", 32'(f_addr), 32'h12);
    chk("wr_wdata", 32'({f_wdata, f_wcrc}), 32'hA55A);
    chk("wr_gid", 32'(f_gid), 1);
    @(negedge clk);
    expect_rsp(0, "wr");
    f_wr = 3'b000;
    @(negedge clk);
    chk("wr_idle", 32'(f_busy), 0);

    // read ch0, rack 2 cycles after ren
    addr[6:0] = 7'h05; bk_rdata = 8'h3C; bk_rcrc = 8'hC3;
    bk_dly = 2; f_rd = 3'b001;
    push(3'b000, 3'b001, 3'b000, 8'h3C);
    @(negedge clk);
    chk("rd_ren", 32'({f_wen, f_ren}), 32'b01);
    chk("rd_addr", 32'(f_addr), 32'h05);
    chk("rd_wdata_hold", 32'(f_wdata), 32'hA5);
    @(negedge clk);
    chk("rd_early", 32'({f_wack, f_rack, f_err}), 0);
    @(negedge clk);
    expect_rsp(0, "rd");
    chk("rd_rcrc", 32'(f_rcrc), 32'hC3);
    f_rd = 3'b000;
    @(negedge clk);

    // fixed priority contention ch0 + ch2
    addr[6:0] = 7'h21; addr[20:14] = 7'h43;
    bk_dly = 1; f_wr = 3'b101;
    push(3'b001, 3'b000, 3'b000, 8'h00);
    push(3'b100, 3'b000, 3'b000, 8'h00);
    @(negedge clk);
    chk("fx_gid0", 32'(f_gid), 0);
    chk("fx_addr0", 32'(f_addr), 32'h21);
    @(negedge clk);
    expect_rsp(0, "fx0");
    f_wr = 3'b100;
    repeat (2) @(negedge clk);
    chk("fx_gid2", 32'(f_gid), 2);
    chk("fx_addr2", 32'(f_addr), 32'h43);
    @(negedge clk);
    expect_rsp(0, "fx2");
    f_wr = 3'b000;
    @(negedge clk);

    // round-robin fairness, all channels hold requests
    rr_sel = 1'b1;
    bk_dly = 1; r_wr = 3'b111;
    for (int k = 0; k < 6; k++) begin
      push(3'(1 << (k % 3)), 3'b000, 3'b000, 8'h00);
      expect_rsp(6, "rr");
      chk("rr_gid", 32'(r_gid), 32'(k % 3));
      if (k == 5) r_wr = 3'b000;
      @(negedge clk);
    end
    rr_sel = 1'b0;
    @(negedge clk);

    // ack timeout on ch2 read
    bk_dly = 0; f_rd = 3'b100;
    push(3'b000, 3'b000, 3'b100, 8'h00);
    @(negedge clk);
    @(negedge clk);
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if ((f_wack | f_rack | f_err) != 3'b0) quiet = 1'b0;
      @(negedge clk);
    end
    chk("to_quiet", 32'(quiet), 1);
    expect_rsp(0, "to");
    f_rd = 3'b000;
    @(negedge clk);
    chk("to_idle", 32'(f_busy), 0);
    tb_rack = 1'b1;
    @(negedge clk);
    chk("to_late", 32'({f_wack, f_rack, f_err}), 0);
    tb_rack = 1'b0;
    @(negedge clk);

    // reset while waiting
    addr[13:7] = 7'h19; wdata[15:8] = 8'h66;
    bk_dly = 0; f_wr = 3'b010;
    repeat (2) @(negedge clk);
    chk("rs_busy", 32'(f_busy), 1);
    rst = 1'b1; tb_wack = 1'b1;
    #1;
    chk("rs_gate", 32'({f_wack, f_rack, f_err, f_busy}), 0);
    @(negedge clk);
    rst = 1'b0; tb_wack = 1'b0; f_wr = 3'b000;
    chk("rs_state", 32'({f_busy, f_gid, f_addr, f_wdata}), 0);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((f_wack | f_rack | f_err) != 3'b0) quiet = 1'b0;
    end
    chk("rs_quiet", 32'(quiet), 1);

    // normal service after reset
    addr[13:7] = 7'h33; wdata[15:8] = 8'h77;
    bk_dly = 1; f_wr = 3'b010;
    push(3'b010, 3'b000, 3'b000, 8'h00);
    expect_rsp(4, "post");
    chk("post_wdata", 32'({f_addr, f_wdata}), 32'h3377);
    f_wr = 3'b000;
    repeat (2) @(negedge clk);
    chk("sbq_empty", 32'(sbq.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
